clz_clo_iter: RTL and testbench

//  Multi-cycle count-leading-zeros/ones unit for the EX stage (MIPS CLZ/CLO).

---
 rtl/clz_clo_iter_pkg.sv | 18 +
 rtl/count_bit_byte.sv | 23 ++
 rtl/clz_clo_iter.sv | 113 +++++++++++
 tb/tb_clz_clo_iter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/clz_clo_iter_pkg.sv
// Shared EX-stage definitions for the iterative CLZ/CLO unit: FSM encoding,
// byte width and the accumulator width helper.
package clz_clo_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int BYTE_W = 8;

    // Counts run 0..data_width inclusive, hence one bit more than clog2.
    function automatic int count_width(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

endpackage

// File: rtl/count_bit_byte.sv
// 8-bit leading-bit counter: number of MSB-first bits equal to lead_bit (0..8).
module count_bit_byte (
    input  logic [7:0] data,
    input  logic       lead_bit,
    output logic [3:0] cnt
);

    logic found;

    // NOTE: every variable driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        cnt   = 4'd8;
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!found && (data[i] != lead_bit)) begin
                cnt   = 4'(7 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clz_clo_iter.sv
// Multi-cycle CLZ/CLO for the EX stage: scans one byte per cycle, MSB byte first.
// Define CLZ_EARLY_EXIT_EN to leave SCAN at the first non-saturated byte.
module clz_clo_iter
    import clz_clo_iter_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  op_clo_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);

    localparam int NBYTES = DATA_WIDTH / BYTE_W;
    localparam int CNT_W  = count_width(DATA_WIDTH);
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  clo_q;
    logic [CNT_W-1:0]      acc_q, acc_sum;
    logic [IDX_W-1:0]      idx_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic [3:0]            byte_cnt;
    logic                  scan_last;
    logic                  accept;
`ifndef CLZ_EARLY_EXIT_EN
    logic                  hit_q;
`endif

    count_bit_byte u_count_bit_byte (
        .data     (shift_q[DATA_WIDTH-1 -: BYTE_W]),
        .lead_bit (clo_q),
        .cnt      (byte_cnt)
    );

    always_comb begin
`ifdef CLZ_EARLY_EXIT_EN
        acc_sum   = acc_q + CNT_W'(byte_cnt);
        scan_last = (idx_q == LAST_IDX) || (byte_cnt != 4'd8);
`else
        // Once a byte breaks the run, later bytes must not contribute.
        acc_sum   = hit_q ? acc_q : acc_q + CNT_W'(byte_cnt);
        scan_last = (idx_q == LAST_IDX);
`endif
        accept = start_i && !flush_i && (state_q != ST_SCAN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start_i) state_d = ST_SCAN;
                ST_SCAN: if (scan_last) state_d = ST_DONE;
                ST_DONE: state_d = start_i ? ST_SCAN : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o   = (state_q == ST_SCAN);
        done_o   = (state_q == ST_DONE);
        result_o = result_q;
    end

    // NOTE: the datapath is reset too, since result_o must read 0 straight
    // out of reset and a stale operand must never leak into a new scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            clo_q    <= 1'b0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
`ifndef CLZ_EARLY_EXIT_EN
            hit_q    <= 1'b0;
`endif
        end else if (accept) begin
            shift_q <= data_i;
            clo_q   <= op_clo_i;
            acc_q   <= '0;
            idx_q   <= '0;
`ifndef CLZ_EARLY_EXIT_EN
            hit_q   <= 1'b0;
`endif
        end else if ((state_q == ST_SCAN) && !flush_i) begin
            shift_q <= shift_q << BYTE_W;
            acc_q   <= acc_sum;
            idx_q   <= idx_q + IDX_W'(1);
`ifndef CLZ_EARLY_EXIT_EN
            hit_q   <= hit_q | (byte_cnt != 4'd8);
`endif
            if (scan_last) result_q <= DATA_WIDTH'(acc_sum);
        end
    end

endmodule

// File: tb/tb_clz_clo_iter.sv
// Scoreboard bench for clz_clo_iter: driver queues expected result and done edge,
// a negedge monitor pops and compares on every done_o pulse.
module tb_clz_clo_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        op_clo_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

`ifdef CLZ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] result;
        int          done_edge;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   n_pass = 0;
    int   n_total = 0;

    clz_clo_iter #(.DATA_WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .op_clo_i (op_clo_i),
        .data_i   (data_i),
        .flush_i  (flush_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every done_o pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", 64'(result_o), 64'(e.result));
                check("done_edge", 64'(edge_cnt), 64'(e.done_edge));
            end
        end
    end

    // Called just after a negedge; holds start_i for exactly one rising edge.
    task automatic launch(input logic clo, input logic [31:0] d);
        start_i  = 1'b1;
        op_clo_i = clo;
        data_i   = d;
        @(negedge clk);
        start_i  = 1'b0;
    endtask

    task automatic issue(input logic clo, input logic [31:0] d, input int res, input int k_early);
        exp_t e;
        e.result    = 32'(res);
        e.done_edge = edge_cnt + 1 + (EARLY ? k_early : 4);
        sb_q.push_back(e);
        launch(clo, d);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    initial begin
        #1;
        check("reset_busy", 64'(busy_o), 64'd0);
        check("reset_done", 64'(done_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic CLZ/CLO vectors, saturated and boundary operands.
        issue(1'b0, 32'h0001_0000, 15, 2); drain();
        issue(1'b0, 32'h0000_0000, 32, 4); drain();
        issue(1'b1, 32'hFFFF_FFFF, 32, 4); drain();
        issue(1'b1, 32'hFF7F_0000,  8, 2); drain();
        issue(1'b0, 32'h00F0_0000,  8, 2); drain();
        issue(1'b0, 32'h8000_0000,  0, 1); drain();
        issue(1'b1, 32'h00FF_FFFF,  0, 1); drain();
        issue(1'b0, 32'h0000_0001, 31, 4); drain();

        // Back-to-back: start ignored while busy, then accepted in the DONE cycle.
        begin
            int n = 0;
            issue(1'b0, 32'h0000_FFFF, 16, 3);
            start_i  = 1'b1;
            op_clo_i = 1'b1;
            data_i   = 32'hFFFF_FFFF;
            @(negedge clk);
            start_i = 1'b0;
            while (!done_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("b2b_first_done", 64'(done_o), 64'd1);
            issue(1'b1, 32'hF000_0000, 4, 1);
            drain();
            @(negedge clk);
            check("result_hold", 64'(result_o), 64'd4);
        end

        // Flush in the second SCAN cycle.
        launch(1'b0, 32'h0000_0000);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        check("flush_done", 64'(done_o), 64'd0);
        check("flush_result", 64'(result_o), 64'd4);

        // Flush together with start: nothing starts.
        flush_i  = 1'b1;
        start_i  = 1'b1;
        op_clo_i = 1'b0;
        data_i   = 32'h0000_0000;
        @(negedge clk);
        flush_i = 1'b0;
        start_i = 1'b0;
        check("flush_start_busy", 64'(busy_o), 64'd0);
        repeat (6) @(negedge clk);
        check("flush_start_idle", 64'(busy_o), 64'd0);
        check("flush_start_result", 64'(result_o), 64'd4);

        // Asynchronous reset in the middle of a scan.
        launch(1'b0, 32'h0000_0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy_o), 64'd0);
        check("rst_mid_done", 64'(done_o), 64'd0);
        check("rst_mid_result", 64'(result_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 32'h0001_FFFF, 15, 2); drain();

        repeat (3) @(negedge clk);
        check("final_busy", 64'(busy_o), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
